rtc_lector_fecha: RTL
=====================

Name: rtc_lector_fecha

Overview:
- Reads the calendar date (day, month, year) back from the external RTC chip over its multiplexed address/data parallel bus.
- Converts the BCD register contents to binary.
- Presents the result to the display/setting logic, using the same day encoding as the button-driven day counter (5-bit, range 1..31).
- Acts as the read side of the date path; the setting counters are the write side.

Parameters:
- PULSE_CYC, 4, clk cycles each strobe (wr_n or rd_n) stays low; min 1.
- GAP_CYC, 2, clk cycles with all strobes high between phases; min 1.
- ADDR_DIA, 8'h24, RTC register address of day.
- ADDR_MES, 8'h25, RTC register address of month.
- ADDR_ANIO, 8'h26, RTC register address of year.
- REFRESH_CYC, 1000000, auto-refresh period in clk cycles; used only with RTC_AUTO_REFRESH_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inicio  in  1  single-cycle read request.
- ad_in  in  8  RTC bus data as driven by the chip.
- ad_out  out  8  address driven to the RTC bus.
- ad_oe  out  1  1 = block drives ad_out onto the bus.
- cs_n  out  1  RTC chip select, active low.
- a_d  out  1  0 = address phase, 1 = data phase.
- wr_n  out  1  write strobe, active low; latches the address.
- rd_n  out  1  read strobe, active low.
- ocupado  out  1  high while a read sequence is in progress.
- valido  out  1  one-cycle pulse when a sequence completes without error.
- error  out  1  one-cycle pulse when a sequence completes with invalid data.
- dia  out  5  day, binary 1..31.
- mes  out  4  month, binary 1..12.
- anio  out  7  year, binary 0..99.

Behaviour:
- Reset (async, rst_n=0), effective immediately mid-sequence:
  - Strobes: cs_n=wr_n=rd_n=1, a_d=0, ad_oe=0, ad_out=0.
  - Status: ocupado=0, valido=0, error=0.
  - Outputs: dia=1, mes=1, anio=0.
  - FSM returns to IDLE.
- FSM states: IDLE -> ADDR -> GAP1 -> DATA -> GAP2 -> (next register: ADDR | last register: FIN) -> IDLE.
  - Register order: day, month, year.
- IDLE:
  - All strobes high.
  - inicio=1 -> ADDR on the next edge, with register index = day and ocupado=1.
- ADDR, PULSE_CYC cycles:
  - cs_n=0, a_d=0, wr_n=0, ad_oe=1.
  - ad_out = address of the current register.
- GAP1 and GAP2, GAP_CYC cycles each:
  - cs_n=wr_n=rd_n=1, ad_oe=0.
  - a_d holds its previous value.
- DATA, PULSE_CYC cycles:
  - cs_n=0, a_d=1, rd_n=0, ad_oe=0.
  - ad_in is captured into the current raw register on the rising edge that ends the last DATA cycle.
- ad_oe and rd_n are never both asserted. ad_oe deasserts on the same edge wr_n rises.
- Sequence length: 6*(PULSE_CYC+GAP_CYC) cycles from the first ADDR cycle to the end of the last GAP2 (36 at defaults). Then one FIN cycle.
- FIN cycle:
  - Decode: day = raw[5:0], month = raw[4:0], year = raw[7:0].
  - Binary value = 10*tens + units.
  - Error if any nibble > 9, day not in 1..31, month not in 1..12, or year > 99.
  - No error: dia/mes/anio are updated and valido pulses.
  - Error: dia/mes/anio keep their previous values and error pulses.
  - The pulse appears in the cycle after FIN.
  - ocupado falls with the pulse.
- Output updates are atomic: all three outputs change together, never one at a time.
- inicio while ocupado=1 is ignored; it is not queued.
- inicio on the same cycle the pulse is issued is ignored. A request is accepted only in IDLE with ocupado=0.
- ad_in is treated as stable during DATA. No synchronizer is required; the RTC data path is slow relative to clk.

Optional Feature:
- RTC_AUTO_REFRESH_EN defined:
  - A free-running counter issues an internal request every REFRESH_CYC cycles.
  - The request is ORed with inicio. If it lands while ocupado=1, it is dropped; the counter is not held.
  - The counter resets to 0 on rst_n.
- RTC_AUTO_REFRESH_EN undefined:
  - The counter is not synthesized; only inicio starts a read.
  - The REFRESH_CYC parameter is unused.

Test Plan:
- Reset then idle: rst_n low then high, no inicio -> dia=1, mes=1, anio=0, cs_n=wr_n=rd_n=1, ad_oe=0.
- Nominal read: bench RTC model returns 0x31/0x12/0x99, pulse inicio -> ad_out shows 0x24, 0x25, 0x26 on successive wr_n pulses. valido pulses 37 cycles after the first ADDR cycle. Outputs: dia=31, mes=12, anio=99.
- Invalid BCD: model returns day 0x3A -> error pulses once, valido stays 0, dia/mes/anio unchanged from the prior read.
- Range checks: day 0x00 -> error; month 0x13 -> error; day 0x01 with month 0x01 -> dia=1, mes=1, valido.
- Busy overlap: inicio repeated every cycle during a sequence -> exactly one sequence runs and ocupado stays continuous. One cycle after the pulse, ocupado=0 and a new inicio is accepted.
- Reset mid-DATA: assert rst_n during rd_n=0 of the month read -> rd_n=cs_n=1 immediately, outputs return to 1/1/0, no valido.

Source files
------------

// File: rtl/rtc_lector_fecha.sv
// rtc_lector_fecha
// ----------------
// Reads the calendar date (day, month, year) back from the external RTC chip
// over its multiplexed address/data bus, converts the BCD register contents
// to binary, and presents it to the display/setting logic. This is the read
// side of the date path; the button-driven setting counters are the write side.
//
// One read sequence walks three registers (day, month, year). Each register
// takes an address phase (wr_n low), a gap, a data phase (rd_n low) and a
// second gap. One decode cycle follows, and then a one-cycle valido or error
// pulse.
//
// Optional build macro:
//   RTC_AUTO_REFRESH_EN - adds a free-running counter that raises an internal
//                         read request every REFRESH_CYC clocks.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   inicio   in   single-cycle read request
//   ad_in    in   [7:0] RTC bus data driven by the chip
//   ad_out   out  [7:0] register address driven onto the bus
//   ad_oe    out  1 = ad_out is driven onto the bus
//   cs_n     out  RTC chip select, active low
//   a_d      out  0 = address phase, 1 = data phase
//   wr_n     out  write strobe, active low (latches the address)
//   rd_n     out  read strobe, active low
//   ocupado  out  high while a read sequence is in progress
//   valido   out  one-cycle pulse, sequence finished with good data
//   error    out  one-cycle pulse, sequence finished with invalid data
//   dia      out  [4:0] day, 1..31
//   mes      out  [3:0] month, 1..12
//   anio     out  [6:0] year, 0..99

`timescale 1ns/1ps

module rtc_lector_fecha #(
  parameter int         PULSE_CYC   = 4,
  parameter int         GAP_CYC     = 2,
  parameter logic [7:0] ADDR_DIA    = 8'h24,
  parameter logic [7:0] ADDR_MES    = 8'h25,
  parameter logic [7:0] ADDR_ANIO   = 8'h26,
  parameter int         REFRESH_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       a_d,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ocupado,
  output logic       valido,
  output logic       error,
  output logic [4:0] dia,
  output logic [3:0] mes,
  output logic [6:0] anio
);

  // Reject nonsensical timing at elaboration time.
  if (PULSE_CYC < 1 || GAP_CYC < 1 || REFRESH_CYC < 1) begin : g_param_check
    $error("rtc_lector_fecha: PULSE_CYC, GAP_CYC and REFRESH_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP1,
    DATA,
    GAP2,
    FIN
  } state_t;

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYC - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);

  // Register index within a sequence: 0 = day, 1 = month, 2 = year.
  localparam logic [1:0] IDX_DIA  = 2'd0;
  localparam logic [1:0] IDX_MES  = 2'd1;
  localparam logic [1:0] IDX_ANIO = 2'd2;

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [1:0]  idx, idx_nx;

  logic        req;
  logic        start;

  logic [7:0]  ad_out_nx;
  logic        ad_oe_nx, cs_n_nx, a_d_nx, wr_n_nx, rd_n_nx;

  // Raw BCD as captured; only the bits that carry the value are kept.
  logic [5:0]  raw_dia;
  logic [4:0]  raw_mes;
  logic [7:0]  raw_anio;

  logic [6:0]  dia_bin;
  logic [6:0]  mes_bin;
  logic [7:0]  anio_bin;
  logic        dec_err;

  // Read request source: the external pulse, optionally ORed with a
  // periodic refresh tick. The refresh counter never pauses, so a tick that
  // lands during a busy sequence is simply lost.
`ifdef RTC_AUTO_REFRESH_EN
  localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYC - 1);

  logic [31:0] ref_cnt;
  logic        auto_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
    end else if (ref_cnt == REFRESH_LAST) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + 32'd1;
    end
  end

  assign auto_req = (ref_cnt == REFRESH_LAST);
  assign req      = inicio | auto_req;
`else
  assign req = inicio;
`endif

  // A request is taken only from a quiet IDLE: the cycle carrying the
  // valido/error pulse is excluded so a request there is dropped.
  assign start = req && (state == IDLE) && !valido && !error;

  // State, phase counter and register index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= IDX_DIA;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state logic, then bus strobes derived from the state being entered
  // so that the registered strobes line up exactly with the state.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    ad_out_nx = 8'h00;
    ad_oe_nx  = 1'b0;
    cs_n_nx   = 1'b1;
    a_d_nx    = a_d;
    wr_n_nx   = 1'b1;
    rd_n_nx   = 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ADDR;
          cnt_nx   = '0;
          idx_nx   = IDX_DIA;
        end
      end
      ADDR: begin
        if (cnt == PULSE_LAST) begin
          state_nx = GAP1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      GAP1: begin
        if (cnt == GAP_LAST) begin
          state_nx = DATA;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == PULSE_LAST) begin
          state_nx = GAP2;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      GAP2: begin
        if (cnt == GAP_LAST) begin
          cnt_nx = '0;
          if (idx == IDX_ANIO) begin
            state_nx = FIN;
          end else begin
            state_nx = ADDR;
            idx_nx   = idx + 2'd1;
          end
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    case (state_nx)
      IDLE: begin
        a_d_nx = 1'b0;
      end
      ADDR: begin
        cs_n_nx  = 1'b0;
        a_d_nx   = 1'b0;
        wr_n_nx  = 1'b0;
        ad_oe_nx = 1'b1;
        case (idx_nx)
          IDX_DIA: ad_out_nx = ADDR_DIA;
          IDX_MES: ad_out_nx = ADDR_MES;
          default: ad_out_nx = ADDR_ANIO;
        endcase
      end
      DATA: begin
        cs_n_nx = 1'b0;
        a_d_nx  = 1'b1;
        rd_n_nx = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Registered bus outputs; reset forces the bus idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ad_out  <= 8'h00;
      ad_oe   <= 1'b0;
      cs_n    <= 1'b1;
      a_d     <= 1'b0;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      ocupado <= 1'b0;
    end else begin
      ad_out  <= ad_out_nx;
      ad_oe   <= ad_oe_nx;
      cs_n    <= cs_n_nx;
      a_d     <= a_d_nx;
      wr_n    <= wr_n_nx;
      rd_n    <= rd_n_nx;
      ocupado <= (state_nx != IDLE);
    end
  end

  // Capture the bus on the edge that closes the final DATA cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_dia  <= '0;
      raw_mes  <= '0;
      raw_anio <= '0;
    end else if (state == DATA && cnt == PULSE_LAST) begin
      case (idx)
        IDX_DIA: raw_dia  <= ad_in[5:0];
        IDX_MES: raw_mes  <= ad_in[4:0];
        default: raw_anio <= ad_in;
      endcase
    end
  end

  // BCD to binary. Widths leave headroom so out-of-range codes stay
  // distinguishable from legal values when checked below.
  always_comb begin
    dia_bin  = {5'd0, raw_dia[5:4]} * 7'd10 + {3'd0, raw_dia[3:0]};
    mes_bin  = {6'd0, raw_mes[4]} * 7'd10 + {3'd0, raw_mes[3:0]};
    anio_bin = {4'd0, raw_anio[7:4]} * 8'd10 + {4'd0, raw_anio[3:0]};

    dec_err  = 1'b0;
    if (raw_dia[3:0] > 4'd9 || raw_mes[3:0] > 4'd9 ||
        raw_anio[7:4] > 4'd9 || raw_anio[3:0] > 4'd9) begin
      dec_err = 1'b1;
    end
    if (dia_bin == 7'd0 || dia_bin > 7'd31) begin
      dec_err = 1'b1;
    end
    if (mes_bin == 7'd0 || mes_bin > 7'd12) begin
      dec_err = 1'b1;
    end
    if (anio_bin > 8'd99) begin
      dec_err = 1'b1;
    end
  end

  // Result update in FIN: all three fields load together or not at all,
  // and the status pulse lands in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dia    <= 5'd1;
      mes    <= 4'd1;
      anio   <= 7'd0;
      valido <= 1'b0;
      error  <= 1'b0;
    end else begin
      valido <= 1'b0;
      error  <= 1'b0;
      if (state == FIN) begin
        if (dec_err) begin
          error <= 1'b1;
        end else begin
          valido <= 1'b1;
          dia    <= dia_bin[4:0];
          mes    <= mes_bin[3:0];
          anio   <= anio_bin[6:0];
        end
      end
    end
  end

endmodule
